dummy_mig_lat: RTL and testbench
================================

Name: dummy_mig_lat

Overview:
- Parametrised successor to the 1-clock dummy MIG model: a behavioural stand-in for the 7-series MIG user (app_*) interface, placed under dram_top in FPGA/sim builds without DDR.
- Adds configurable depth, fixed read latency, outstanding-read credit limit, write-data FIFO, calibration delay and periodic app_rdy back-pressure, so the AXI-to-MIG bridge can be exercised under realistic timing.

Parameters:
- AWIDTH, 12: log2 of memory depth in 128-bit words.
- RD_LAT, 8: cycles from read command acceptance to app_rd_data_valid; legal range 2..32.
- RDQ_DEPTH, 4: maximum outstanding reads, 1..8.
- CALIB_CYCLES, 16: cycles after reset release before init_calib_complete rises.
- RDY_PERIOD, 0: 0 means no throttle; N>1 means app_rdy is forced low for one cycle every N cycles.

Ports:
- mclk  in  1  clock; the only clock.
- mrst_n  in  1  asynchronous active-low reset.
- app_addr  in  28  byte-granular address; word index = app_addr[AWIDTH+3:4].
- app_cmd  in  3  3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept.
- app_wdf_data  in  128  write data.
- app_wdf_mask  in  16  per-byte mask; 1 = byte NOT written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; always 1 in this model and checked.
- app_wdf_rdy  out  1  write-data accept.
- app_rd_data  out  128  read data.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- app_rd_data_valid  out  1  read data strobe.
- init_calib_complete  out  1  calibration done.
- err_flag  out  1  sticky flag: illegal cmd, or wren with wdf_end=0.

Behaviour:
- Reset values: all outputs 0. Calibration counter, throttle counter, write-data FIFO, pending-write flag, read pipeline and credit count are all cleared. Memory array is not cleared.
- Calibration: counter runs from reset release; init_calib_complete=1 from cycle CALIB_CYCLES onward. Before that, app_rdy=0 and app_wdf_rdy=0.
- Write-data FIFO: 2 entries of {data,mask}.
  - Push on app_wdf_wren & app_wdf_rdy.
  - app_wdf_rdy = calib & FIFO not full (registered-full based).
  - Simultaneous push and pop on a full FIFO is allowed; count unchanged.
- app_rdy = calib & ~throttle & ~wr_pend & (credits < RDQ_DEPTH).
- Command accepted when app_en & app_rdy.
  - Write, FIFO non-empty (or same-cycle push into an empty FIFO, bypassed): commit the masked byte merge into mem[word] at the acceptance edge; pop FIFO.
  - Write, no data available: set wr_pend and latch the address; app_rdy=0 until data arrives. Commit on the first data-available cycle, then clear wr_pend.
  - Read: read mem[word] at the acceptance edge (after any same-edge write commit, so read-after-write returns new data). Push into an RD_LAT-stage shift pipeline; credits++.
  - Other cmd: consumed, no effect; err_flag set.
- Read return: pipeline output drives app_rd_data, valid and end exactly RD_LAT cycles after acceptance. Returns are in order; back-to-back reads give back-to-back valids. credits-- on each valid. Simultaneous ++/-- leaves the count unchanged.
- Throttle: free-running counter 0..RDY_PERIOD-1 from calib; throttle=1 when count==RDY_PERIOD-1.
- Address wrap: upper bits above AWIDTH+3 ignored (aliasing); app_addr[3:0] ignored.
- Reset mid-read: in-flight reads are discarded; no valid is emitted after reset release.
- Read data is registered; no combinational path from app_en to app_rd_data.

Decomposition:
- Shared package mig_pkg: CMD_WR=3'b000, CMD_RD=3'b001, APP_DW=128, APP_MW=16, APP_AW=28.
- One sub-module, dummy_mig_wdf_fifo: 2-entry {mask,data} FIFO with full/empty flags and same-cycle bypass.
- Read-latency pipeline and memory stay in the top of the block.

Test Plan:
- Calibration: release reset with CALIB_CYCLES=16 -> init_calib_complete, app_rdy and app_wdf_rdy are 0 for cycles 0..15 and 1 at cycle 16; any app_en before that is not accepted.
- Write then read: write data 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, mask 16'h0000 to addr 28'h40, then read addr 28'h40 with RD_LAT=8 -> the same data appears exactly 8 cycles after read acceptance, with end=valid=1 for one cycle.
- Masked write: pre-fill addr 28'h80 with all 0xFF, write data 0 with mask 16'hFF00 -> readback 128'hFFFF..FF_0000..00 (upper 8 bytes kept, lower 8 bytes zeroed).
- Late data: write command at cycle t with no wren -> app_rdy=0 from t+1 until data arrives at t+3; the commit happens at t+3; a later read returns that data.
- Credit limit: RDQ_DEPTH=4, RD_LAT=8, issue 6 reads back-to-back -> app_rdy drops after the 4th; the 5th is accepted the cycle after the first valid; all 6 return in issue order.
- Throttle, illegal cmd and reset: RDY_PERIOD=4 -> app_rdy low every 4th cycle. cmd=3'b010 -> err_flag=1 and stays 1. Assert mrst_n=0 with 2 reads in flight -> no valid after reset release and credits=0.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared constants and write-data types for the dummy MIG app_* interface models.
package mig_pkg;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int APP_DW = 128;
  localparam int APP_MW = 16;
  localparam int APP_AW = 28;

  typedef struct packed {
    logic [APP_MW-1:0] mask;
    logic [APP_DW-1:0] data;
  } wdf_t;

  // Mask bit set means the byte keeps its old contents.
  function automatic logic [APP_DW-1:0] byte_merge(input logic [APP_DW-1:0] old, input wdf_t w);
    logic [APP_DW-1:0] r;
    r = old;
    for (int b = 0; b < APP_MW; b++)
      if (!w.mask[b]) r[b*8 +: 8] = w.data[b*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dummy_mig_wdf_fifo.sv
// Two-entry write-data FIFO; an empty FIFO forwards a same-cycle push straight to head.
module dummy_mig_wdf_fifo
  import mig_pkg::*;
(
  input  logic mclk,
  input  logic mrst_n,
  input  logic push,
  input  wdf_t push_dat,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic avail,
  output wdf_t head
);
  wdf_t       ent [2];
  logic       wptr, rptr;
  logic [1:0] cnt;
  logic       store, take;

  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);
  assign avail = ~empty | push;
  assign head  = empty ? push_dat : ent[rptr];
  assign take  = pop & ~empty;
  // Push and pop together on an empty FIFO is a pure bypass: nothing is stored.
  assign store = push & ~(empty & pop);

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      cnt    <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      if (store) begin
        ent[wptr] <= push_dat;
        wptr      <= ~wptr;
      end
      if (take) rptr <= ~rptr;
      cnt <= cnt + {1'b0, store} - {1'b0, take};
    end
  end
endmodule

// File: rtl/dummy_mig_lat.sv
// Behavioural MIG app_* stand-in with read latency, read credits, write-data FIFO,
// calibration delay and optional periodic app_rdy throttling.
module dummy_mig_lat
  import mig_pkg::*;
#(
  parameter int AWIDTH       = 12,
  parameter int RD_LAT       = 8,
  parameter int RDQ_DEPTH    = 4,
  parameter int CALIB_CYCLES = 16,
  parameter int RDY_PERIOD   = 0
) (
  input  logic              mclk,
  input  logic              mrst_n,
  input  logic [APP_AW-1:0] app_addr,
  input  logic [2:0]        app_cmd,
  input  logic              app_en,
  output logic              app_rdy,
  input  logic [APP_DW-1:0] app_wdf_data,
  input  logic [APP_MW-1:0] app_wdf_mask,
  input  logic              app_wdf_wren,
  input  logic              app_wdf_end,
  output logic              app_wdf_rdy,
  output logic [APP_DW-1:0] app_rd_data,
  output logic              app_rd_data_end,
  output logic              app_rd_data_valid,
  output logic              init_calib_complete,
  output logic              err_flag
);
  localparam int CW = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam int TW = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
  localparam int QW = $clog2(RDQ_DEPTH + 1);

  logic [APP_DW-1:0] mem [2**AWIDTH];

  logic                 calib;
  logic [CW-1:0]        cal_cnt;
  logic                 throttle;
  logic [QW-1:0]        credits;
  logic                 wr_pend;
  logic [AWIDTH-1:0]    pend_word, word, commit_word;
  logic                 acc, wr_acc, rd_acc, bad_cmd, commit, push;
  logic                 full, empty, avail;
  wdf_t                 head, push_dat;
  logic [RD_LAT:1]             vld_pipe;
  logic [RD_LAT:1][APP_DW-1:0] dat_pipe;
  logic                 unused_addr;

  assign word        = app_addr[AWIDTH+3:4];
  assign unused_addr = ^{app_addr[APP_AW-1:AWIDTH+4], app_addr[3:0]};

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      calib   <= 1'b0;
      cal_cnt <= '0;
    end else if (!calib) begin
      if (cal_cnt == CW'(CALIB_CYCLES - 1)) calib <= 1'b1;
      else                                  cal_cnt <= cal_cnt + 1'b1;
    end
  end

  generate
    if (RDY_PERIOD > 1) begin : g_thr
      logic [TW-1:0] thr_cnt;
      always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n)   thr_cnt <= '0;
        else if (calib) thr_cnt <= (thr_cnt == TW'(RDY_PERIOD - 1)) ? '0 : thr_cnt + 1'b1;
      end
      assign throttle = calib & (thr_cnt == TW'(RDY_PERIOD - 1));
    end else begin : g_nothr
      assign throttle = 1'b0;
    end
  endgenerate

  assign app_rdy     = calib & ~throttle & ~wr_pend & (credits < QW'(RDQ_DEPTH));
  assign app_wdf_rdy = calib & ~full;
  assign push        = app_wdf_wren & app_wdf_rdy;
  assign push_dat    = '{mask: app_wdf_mask, data: app_wdf_data};

  assign acc     = app_en & app_rdy;
  assign wr_acc  = acc & (app_cmd == CMD_WR);
  assign rd_acc  = acc & (app_cmd == CMD_RD);
  assign bad_cmd = acc & (app_cmd != CMD_WR) & (app_cmd != CMD_RD);

  // app_rdy is low while wr_pend, so a fresh write and a late commit never coincide.
  assign commit      = (wr_acc | wr_pend) & avail;
  assign commit_word = wr_pend ? pend_word : word;

  dummy_mig_wdf_fifo u_wdf (
    .mclk    (mclk),
    .mrst_n  (mrst_n),
    .push    (push),
    .push_dat(push_dat),
    .pop     (commit),
    .full    (full),
    .empty   (empty),
    .avail   (avail),
    .head    (head)
  );

  always_ff @(posedge mclk) begin
    if (commit) mem[commit_word] <= byte_merge(mem[commit_word], head);
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      wr_pend   <= 1'b0;
      pend_word <= '0;
    end else if (wr_acc & ~avail) begin
      wr_pend   <= 1'b1;
      pend_word <= word;
    end else if (wr_pend & avail) begin
      wr_pend   <= 1'b0;
    end
  end

  // Stage 1 is the registered memory read; the last stage drives the read port.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      dat_pipe[1] <= rd_acc ? mem[word] : '0;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign app_rd_data       = dat_pipe[RD_LAT];
  assign app_rd_data_valid = vld_pipe[RD_LAT];
  assign app_rd_data_end   = vld_pipe[RD_LAT];

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      credits <= '0;
    end else begin
      case ({rd_acc, vld_pipe[RD_LAT]})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n)                                     err_flag <= 1'b0;
    else if (bad_cmd | (app_wdf_wren & ~app_wdf_end)) err_flag <= 1'b1;
  end

  assign init_calib_complete = calib;
endmodule

// File: tb/tb_dummy_mig_lat.sv
// Directed bench for dummy_mig_lat: calibration, latency, masking, late data,
// FIFO ordering, credits, throttle, illegal command and reset mid-read.
module tb_dummy_mig_lat;
  logic         mclk = 1'b0;
  logic         mrst_n = 1'b0;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = 3'b000;
  logic         app_en = 1'b0;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b1;
  logic         app_rdy, app_wdf_rdy, app_rd_data_end, app_rd_data_valid;
  logic         init_calib_complete, err_flag;
  logic [127:0] app_rd_data;

  logic [27:0]  t_addr = '0;
  logic [2:0]   t_cmd = 3'b000;
  logic         t_en = 1'b0;
  logic [127:0] t_wdata = '0;
  logic [15:0]  t_wmask = '0;
  logic         t_wren = 1'b0;
  logic         t_wend = 1'b1;
  logic         t_rdy, t_wdf_rdy, t_rd_end, t_rd_valid, t_calib, t_err;
  logic [127:0] t_rd_data;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] DM = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] D4 = 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D5 = 128'h5A5A_5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA;

  always #5 mclk = ~mclk;

  dummy_mig_lat u_dut (
    .mclk(mclk), .mrst_n(mrst_n), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
    .app_rd_data_valid(app_rd_data_valid), .init_calib_complete(init_calib_complete),
    .err_flag(err_flag)
  );

  dummy_mig_lat #(.RDY_PERIOD(4)) u_thr (
    .mclk(mclk), .mrst_n(mrst_n), .app_addr(t_addr), .app_cmd(t_cmd),
    .app_en(t_en), .app_rdy(t_rdy), .app_wdf_data(t_wdata),
    .app_wdf_mask(t_wmask), .app_wdf_wren(t_wren), .app_wdf_end(t_wend),
    .app_wdf_rdy(t_wdf_rdy), .app_rd_data(t_rd_data), .app_rd_data_end(t_rd_end),
    .app_rd_data_valid(t_rd_valid), .init_calib_complete(t_calib), .err_flag(t_err)
  );

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    chk("wr_rdy", app_rdy, 1);
    chk("wr_wdf_rdy", app_wdf_rdy, 1);
    step();
    app_en = 1'b0; app_wdf_wren = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [27:0] a, input logic [127:0] exp);
    app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
    chk({tag, "_rdy"}, app_rdy, 1);
    step();
    app_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk({tag, "_vld"}, app_rd_data_valid, (k == 8));
      if (k == 8) begin
        chk({tag, "_data"}, app_rd_data, exp);
        chk({tag, "_end"}, app_rd_data_end, 1);
      end
      step();
    end
    chk({tag, "_vld_after"}, app_rd_data_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0]  cr_addr [6];
    logic [127:0] cr_data [6];
    int ii, vi;
    logic exp_v, en_now;

    // Reset state
    repeat (3) step();
    chk("rst_calib", init_calib_complete, 0);
    chk("rst_rdy", app_rdy, 0);
    chk("rst_wdf_rdy", app_wdf_rdy, 0);
    chk("rst_vld", app_rd_data_valid, 0);
    chk("rst_data", app_rd_data, 0);
    chk("rst_err", err_flag, 0);

    // Calibration and throttle pattern; read requests before calib must be ignored
    mrst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      app_en = (c < 16); app_cmd = 3'b001; app_addr = '0;
      chk("cal_done", init_calib_complete, (c >= 16));
      chk("cal_rdy", app_rdy, (c >= 16));
      chk("cal_wdf_rdy", app_wdf_rdy, (c >= 16));
      chk("cal_noacc", app_rd_data_valid, 0);
      chk("thr_rdy", t_rdy, (c >= 16) && ((c - 16) % 4 != 3));
      step();
    end
    app_en = 1'b0;

    // Write then read
    wr(28'h40, D1, 16'h0000);
    rd_chk("wr_rd", 28'h40, D1);

    // Masked write
    wr(28'h80, {128{1'b1}}, 16'h0000);
    wr(28'h80, 128'h0, 16'hFF00);
    rd_chk("mask", 28'h80, DM);

    // Late data
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'hC0; app_wdf_wren = 1'b0;
    chk("late_rdy_t", app_rdy, 1);
    step();
    app_en = 1'b0;
    chk("late_rdy_t1", app_rdy, 0);
    step();
    chk("late_rdy_t2", app_rdy, 0);
    step();
    app_wdf_wren = 1'b1; app_wdf_data = D3; app_wdf_mask = 16'h0000;
    chk("late_rdy_t3", app_rdy, 0);
    chk("late_wdf_rdy", app_wdf_rdy, 1);
    step();
    app_wdf_wren = 1'b0;
    chk("late_rdy_t4", app_rdy, 1);
    rd_chk("late", 28'hC0, D3);

    // Data ahead of commands: fill FIFO, check full, commit in order
    app_wdf_wren = 1'b1; app_wdf_data = D4;
    chk("fifo_rdy0", app_wdf_rdy, 1);
    step();
    app_wdf_data = D5;
    chk("fifo_rdy1", app_wdf_rdy, 1);
    step();
    app_wdf_wren = 1'b0;
    chk("fifo_full", app_wdf_rdy, 0);
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h100;
    chk("fifo_cmd0", app_rdy, 1);
    step();
    chk("fifo_notfull", app_wdf_rdy, 1);
    app_addr = 28'h140;
    chk("fifo_cmd1", app_rdy, 1);
    step();
    app_en = 1'b0;
    rd_chk("alias", 28'h010_010F, D4);
    rd_chk("fifo2", 28'h140, D5);

    // Credit limit: 6 back-to-back reads, RDQ_DEPTH=4, RD_LAT=8
    cr_addr[0] = 28'h40;  cr_data[0] = D1;
    cr_addr[1] = 28'h80;  cr_data[1] = DM;
    cr_addr[2] = 28'hC0;  cr_data[2] = D3;
    cr_addr[3] = 28'h100; cr_data[3] = D4;
    cr_addr[4] = 28'h140; cr_data[4] = D5;
    cr_addr[5] = 28'h40;  cr_data[5] = D1;
    ii = 0; vi = 0;
    for (int k = 0; k < 20; k++) begin
      en_now = (k <= 3) || (k == 9) || (k == 10);
      app_en = en_now; app_cmd = 3'b001; app_addr = cr_addr[ii];
      if (k <= 10) chk("cr_rdy", app_rdy, (k <= 3) || (k >= 9));
      exp_v = (k >= 8 && k <= 11) || k == 17 || k == 18;
      chk("cr_vld", app_rd_data_valid, exp_v);
      if (exp_v) begin
        chk("cr_data", app_rd_data, cr_data[vi]);
        vi++;
      end
      step();
      if (en_now && ii < 5) ii++;
    end
    app_en = 1'b0;

    // Illegal command
    chk("err_pre", err_flag, 0);
    app_en = 1'b1; app_cmd = 3'b010;
    chk("bad_rdy", app_rdy, 1);
    step();
    app_en = 1'b0;
    chk("err_set", err_flag, 1);
    repeat (3) step();
    chk("err_sticky", err_flag, 1);

    // Reset with two reads in flight
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h40;
    step(); step();
    app_en = 1'b0;
    repeat (3) step();
    mrst_n = 1'b0;
    #1;
    chk("mrst_vld", app_rd_data_valid, 0);
    chk("mrst_calib", init_calib_complete, 0);
    chk("mrst_rdy", app_rdy, 0);
    chk("mrst_err", err_flag, 0);
    step(); step();
    mrst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      chk("mrst_noval", app_rd_data_valid, 0);
      step();
    end
    // A full set of RDQ_DEPTH reads must be accepted, proving credits restarted at 0
    for (int k = 0; k < 9; k++) begin
      app_en = (k < 4); app_cmd = 3'b001; app_addr = 28'h40;
      if (k <= 4) chk("mrst_cr_rdy", app_rdy, (k < 4));
      chk("mrst_cr_vld", app_rd_data_valid, (k == 8));
      if (k == 8) chk("mrst_cr_data", app_rd_data, D1);
      step();
    end
    app_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
